// File: rtl/mult_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Multi-cycle signed multiply / divide engine. Performs one
//             unsigned shift-add (MULT) or restoring shift-subtract (DIV)
//             step per clock on operand magnitudes, applies the sign
//             correction in a final cycle and writes the result into HI/LO.
//  Ports    : clk          - clock, rising edge
//             reset        - synchronous, active-high reset
//             start        - operation request, sampled only when idle
//             ALU_Control  - 3-bit op code (OP_MULT / OP_DIV)
//             a, b         - two's complement operands (rs, rt)
//             busy         - engine occupied, datapath should stall
//             done         - one-cycle pulse, HI/LO valid
//             hi, lo       - MULT: product halves; DIV: remainder / quotient
//             div_by_zero  - set with done when a DIV had b == 0
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] OP_MULT = 3'b011,
    parameter logic [2:0] OP_DIV  = 3'b100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALU_Control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operation context captured at acceptance
    logic                 r_op_div;
    logic                 r_neg_res;   // sign(a) ^ sign(b)
    logic                 r_neg_rem;   // sign(a): remainder follows dividend
    logic [WIDTH-1:0]     r_m;         // multiplicand (MULT) or divisor (DIV) magnitude
    logic [2*WIDTH-1:0]   r_acc;       // {upper, lower} working register
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_dbz;

    logic                 w_legal_op;
    logic                 w_accept;
    logic                 w_is_div;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_diff;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [2*WIDTH-1:0]   w_prod_signed;
    logic [WIDTH-1:0]     w_quo_signed;
    logic [WIDTH-1:0]     w_rem_signed;

    assign w_is_div   = (ALU_Control == OP_DIV);
    assign w_legal_op = (ALU_Control == OP_MULT) || w_is_div;
    assign w_accept   = (r_state == S_IDLE) && start && w_legal_op;
    assign w_b_zero   = (b == '0);

    // Magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned
    assign w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Shift-add: multiplier sits in the low half and is consumed LSB first
    // while the partial product grows in from the top.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_m : '0)};
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring division: remainder in the high half, dividend shifted out of
    // the low half MSB first while quotient bits enter at the LSB.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
    // Difference is below the divisor whenever it is used, so WIDTH bits suffice
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_m;
    assign w_div_step  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    assign w_prod_signed = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_signed  = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem_signed  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                     : r_acc[2*WIDTH-1:WIDTH];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_is_div && w_b_zero) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_last_cnt) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_m       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_div  <= w_is_div;
                        r_neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_rem <= a[WIDTH-1];
                        r_cnt     <= '0;
                        r_dbz     <= 1'b0;
                        if (w_is_div) begin
                            r_m   <= w_abs_b;
                            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                            // Divide by zero finishes immediately with a fixed result
                            if (w_b_zero) begin
                                r_hi  <= a;
                                r_lo  <= '1;
                                r_dbz <= 1'b1;
                            end
                        end else begin
                            r_m   <= w_abs_a;
                            r_acc <= {{WIDTH{1'b0}}, w_abs_b};
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_op_div ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_op_div) begin
                        r_hi <= w_rem_signed;
                        r_lo <= w_quo_signed;
                    end else begin
                        r_hi <= w_prod_signed[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_signed[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Self-checking bench for mult_div_unit: directed and random
//             MULT/DIV operations compared against signed 64-bit arithmetic,
//             plus protocol cases (illegal op, start while busy, start in the
//             done cycle, reset mid-operation).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int         W   = 32;
    localparam logic [2:0] OPM = 3'b011;
    localparam logic [2:0] OPD = 3'b100;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   alu;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;

    int errors = 0;
    int checks = 0;

    // Expected architectural HI/LO/flag state
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         m_dbz;

    mult_div_unit #(.WIDTH(W), .OP_MULT(OPM), .OP_DIV(OPD)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ALU_Control (alu),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers
    task automatic model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] eh, output logic [W-1:0] el,
                         output logic ed, output int ec);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (op == OPM) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
            ed = 1'b0;
            ec = W + 2;
        end else if (bv == '0) begin
            eh = av;
            el = '1;
            ed = 1'b1;
            ec = 1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
            ed = 1'b0;
            ec = W + 2;
        end
    endtask

    // Issue one op and follow it to completion. inj_start / inj_reset name the
    // cycle (counted from the accept edge) at which a stray start or a reset
    // is driven; 0 disables. start_in_done drives start during the done cycle.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int inj_start, input int inj_reset, input bit start_in_done);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         ed;
        int           ec;
        int           dc;
        bit           busy_ok;
        model(op, av, bv, eh, el, ed, ec);
        @(negedge clk);
        start = 1'b1; alu = op; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; alu = 3'($urandom);
        dc = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= W + 8; k++) begin
            if (k > 1) @(negedge clk);
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                dc = k;
                break;
            end
            if (k == inj_start) begin
                start = 1'b1; alu = OPM; a = $urandom; b = $urandom;
            end
            if (k == inj_reset) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check({tag, " rst busy"}, 64'(busy), 64'd0);
                check({tag, " rst done"}, 64'(done), 64'd0);
                check({tag, " rst hi"},   64'(hi),   64'd0);
                check({tag, " rst lo"},   64'(lo),   64'd0);
                check({tag, " rst dbz"},  64'(dbz),  64'd0);
                m_hi = '0; m_lo = '0; m_dbz = 1'b0;
                return;
            end
        end
        check({tag, " done cycle"}, 64'(dc), 64'(ec));
        check({tag, " busy held"},  64'(busy_ok), 64'd1);
        check({tag, " hi"},  64'(hi),  64'(eh));
        check({tag, " lo"},  64'(lo),  64'(el));
        check({tag, " dbz"}, 64'(dbz), 64'(ed));
        m_hi = eh; m_lo = el; m_dbz = ed;
        if (start_in_done) begin
            start = 1'b1; alu = OPM; a = $urandom; b = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " post busy"}, 64'(busy), 64'd0);
        check({tag, " post done"}, 64'(done), 64'd0);
        if (start_in_done) begin
            @(negedge clk);
            check({tag, " done-start ignored"}, 64'(busy), 64'd0);
            check({tag, " hold hi"}, 64'(hi), 64'(m_hi));
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset = 1'b1; start = 1'b0; alu = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi",   64'(hi),   64'd0);
        check("reset lo",   64'(lo),   64'd0);
        check("reset dbz",  64'(dbz),  64'd0);
        reset = 1'b0;

        run_op("mult 7*-3",       OPM, 32'd7,        32'hFFFF_FFFD, 0, 0, 1'b0);
        run_op("mult max*max",    OPM, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 1'b0);
        run_op("div -7/2",        OPD, 32'hFFFF_FFF9, 32'd2,        0, 0, 1'b0);
        run_op("div 5/0",         OPD, 32'd5,        32'd0,        0, 0, 1'b0);
        run_op("div 8/2",         OPD, 32'd8,        32'd2,        0, 0, 1'b0);
        run_op("div min/-1",      OPD, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);

        // Illegal op code: no busy, HI/LO untouched
        @(negedge clk);
        start = 1'b1; alu = 3'b010; a = $urandom; b = $urandom;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("illegal busy", 64'(busy), 64'd0);
            check("illegal hi",   64'(hi),   64'(m_hi));
            check("illegal lo",   64'(lo),   64'(m_lo));
        end

        run_op("mult start@10",   OPM, 32'h1234_5678, 32'hFEDC_BA98, 10, 0, 1'b0);
        run_op("div start@done",  OPD, 32'h8765_4321, 32'h0000_1357, 0, 0, 1'b1);
        run_op("mult reset@15",   OPM, 32'h0BAD_F00D, 32'h0000_0123, 0, 15, 1'b0);
        run_op("mult after rst",  OPM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op("div -min/min",    OPD, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 3) begin
                rb = 32'($urandom_range(0, 6));
                rb = rb - 32'd3;
            end
            run_op($sformatf("rand%0d", i), (i % 2 == 1) ? OPD : OPM, ra, rb, 0, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
